// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encodings,
// default fetch vectors and the boot counter width.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_EXC  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;
  localparam int          BOOT_CNT_W    = 8;

  // Instruction addresses are word aligned; any low bit set is a bad target.
  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_boot_cnt.sv
// Boot-window counter: counts while enabled until it reaches LAST, then holds
// and raises done. Cleared asynchronously by the active-low reset.
module fetch_boot_cnt
  import fetch_ctrl_pkg::*;
#(
  parameter logic [BOOT_CNT_W-1:0] LAST = 8'd3
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic done
);

  logic [BOOT_CNT_W-1:0] count_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else if (en && !done) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign done = (count_q == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: boot window, next-PC selection, redirect,
// stall, halt/resume and misaligned-target exception handling.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC   = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC     = DEF_EXC_VEC,
  parameter int unsigned BOOT_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] cur_pc,
  input  logic [31:0] seq_pc,
  input  logic        stall,
  input  logic        redir_req,
  input  logic [31:0] redir_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] newPC,
  output logic        if_valid,
  output logic        flush,
  output logic        halted,
  output logic        exc_taken,
  output logic [31:0] bad_addr
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES - 1);

  fetch_state_e state_q, state_d;
  logic         boot_done;
  logic         redir_bad;

  assign redir_bad = redir_req && misaligned(redir_pc);

  fetch_boot_cnt #(
    .LAST (BOOT_LAST)
  ) u_boot_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .en   (state_q == ST_BOOT),
    .done (boot_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: if (boot_done) state_d = ST_RUN;
      ST_RUN: begin
        if (redir_bad)                  state_d = ST_EXC;
        else if (!redir_req && halt_req) state_d = ST_HALT;
      end
      ST_EXC:  state_d = ST_RUN;
      ST_HALT: if (resume) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // Redirect outranks halt and stall: both come from instructions that the
  // redirect proves to be on the wrong path.
  always_comb begin
    newPC     = RESET_VEC;
    if_valid  = 1'b0;
    flush     = 1'b0;
    halted    = 1'b0;
    exc_taken = 1'b0;
    case (state_q)
      ST_BOOT: ;
      ST_RUN: begin
        if_valid = 1'b1;
        if (redir_bad) begin
          newPC = cur_pc;
          flush = 1'b1;
        end else if (redir_req) begin
          newPC = redir_pc;
          flush = 1'b1;
        end else if (halt_req) begin
          newPC = cur_pc;
          flush = 1'b1;
        end else if (stall) begin
          newPC = cur_pc;
        end else begin
          newPC = seq_pc;
        end
      end
      ST_EXC: begin
        newPC     = EXC_VEC;
        flush     = 1'b1;
        exc_taken = 1'b1;
      end
      ST_HALT: begin
        newPC  = cur_pc;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bad_addr <= '0;
    end else if (state_q == ST_RUN && redir_bad) begin
      bad_addr <= redir_pc;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic fetch_inc, stall_inc;

  assign fetch_inc = if_valid && !stall;
  assign stall_inc = (state_q == ST_RUN) && stall && !redir_req;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (fetch_inc && perf_fetch != '1) perf_fetch <= perf_fetch + 1'b1;
      if (stall_inc && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
      if (flush && perf_flush != '1)     perf_flush <= perf_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the driver queues the expected outputs of
// each cycle it drives, the monitor compares them on the falling edge.
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] cur_pc = '0, seq_pc = 32'd4, redir_pc = '0;
  logic        stall = 1'b0, redir_req = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] newPC, bad_addr;
  logic        if_valid, flush, halted, exc_taken;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

  fetch_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .cur_pc    (cur_pc),
    .seq_pc    (seq_pc),
    .stall     (stall),
    .redir_req (redir_req),
    .redir_pc  (redir_pc),
    .halt_req  (halt_req),
    .resume    (resume),
    .newPC     (newPC),
    .if_valid  (if_valid),
    .flush     (flush),
    .halted    (halted),
    .exc_taken (exc_taken),
    .bad_addr  (bad_addr)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        halted;
    logic        exc;
    logic [31:0] bad;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h ({newPC,valid,flush,halted,exc,bad_addr})",
               nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, {newPC, if_valid, flush, halted, exc_taken, bad_addr},
            {e.pc, e.valid, e.flush, e.halted, e.exc, e.bad});
    end
  end

  // One cycle: drive inputs just after the rising edge, queue what the
  // outputs must be for the rest of that cycle.
  task automatic step(input string nm, input logic rstv, input logic [31:0] pc,
                      input logic st, input logic rq, input logic [31:0] rpc,
                      input logic hr, input logic rs,
                      input logic [31:0] e_pc, input logic e_v, input logic e_f,
                      input logic e_h, input logic e_x, input logic [31:0] e_bad);
    exp_t e;
    @(posedge CLK);
    #1;
    RST       = rstv;
    cur_pc    = pc;
    seq_pc    = pc + 32'd4;
    stall     = st;
    redir_req = rq;
    redir_pc  = rpc;
    halt_req  = hr;
    resume    = rs;
    e.name = nm; e.pc = e_pc; e.valid = e_v; e.flush = e_f;
    e.halted = e_h; e.exc = e_x; e.bad = e_bad;
    sb_q.push_back(e);
  endtask

  task automatic boot_window(input string nm);
    for (int i = 0; i < 4; i++)
      step($sformatf("%s_boot%0d", nm, i), 1, 32'h0, 1, 1, 32'h42, 1, 1,
           32'h0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every request asserted: nothing may leak through.
    step("reset", 0, 32'h0, 1, 1, 32'h42, 1, 1, 32'h0, 0, 0, 0, 0, 32'h0);
    boot_window("first");
    step("run_first",   1, 32'h00, 0, 0, 32'h0,   0, 0, 32'h04, 1, 0, 0, 0, 32'h0);
    step("run_seq",     1, 32'h04, 0, 0, 32'h0,   0, 0, 32'h08, 1, 0, 0, 0, 32'h0);
    step("stall1",      1, 32'h10, 1, 0, 32'h0,   0, 0, 32'h10, 1, 0, 0, 0, 32'h0);
    step("stall2",      1, 32'h10, 1, 0, 32'h0,   0, 0, 32'h10, 1, 0, 0, 0, 32'h0);
    step("stall_redir", 1, 32'h10, 1, 1, 32'h40,  0, 0, 32'h40, 1, 1, 0, 0, 32'h0);
    step("at_target",   1, 32'h40, 0, 0, 32'h0,   0, 0, 32'h44, 1, 0, 0, 0, 32'h0);
    step("misaligned",  1, 32'h44, 0, 1, 32'h42,  0, 0, 32'h44, 1, 1, 0, 0, 32'h0);
    step("exc_entry",   1, 32'h44, 0, 0, 32'h0,   0, 0, 32'h80, 0, 1, 0, 1, 32'h42);
    step("after_exc",   1, 32'h80, 0, 0, 32'h0,   0, 0, 32'h84, 1, 0, 0, 0, 32'h42);
    step("halt_req",    1, 32'h20, 0, 0, 32'h0,   1, 0, 32'h20, 1, 1, 0, 0, 32'h42);
    step("halt_hold1",  1, 32'h20, 1, 0, 32'h0,   0, 0, 32'h20, 0, 0, 1, 0, 32'h42);
    step("halt_hold2",  1, 32'h20, 0, 1, 32'h300, 0, 0, 32'h20, 0, 0, 1, 0, 32'h42);
    step("halt_hold3",  1, 32'h20, 1, 1, 32'h301, 0, 0, 32'h20, 0, 0, 1, 0, 32'h42);
    step("resume",      1, 32'h20, 0, 0, 32'h0,   0, 1, 32'h20, 0, 0, 1, 0, 32'h42);
    step("post_resume", 1, 32'h20, 0, 0, 32'h0,   0, 0, 32'h24, 1, 0, 0, 0, 32'h42);
    step("resume_run",  1, 32'h24, 0, 0, 32'h0,   0, 1, 32'h28, 1, 0, 0, 0, 32'h42);
    step("halt_vs_redir", 1, 32'h28, 0, 1, 32'h100, 1, 0, 32'h100, 1, 1, 0, 0, 32'h42);
    step("no_halt",     1, 32'h100, 0, 0, 32'h0,  0, 0, 32'h104, 1, 0, 0, 0, 32'h42);
    step("halt_again",  1, 32'h104, 0, 0, 32'h0,  1, 0, 32'h104, 1, 1, 0, 0, 32'h42);
    step("halted",      1, 32'h104, 0, 0, 32'h0,  0, 0, 32'h104, 0, 0, 1, 0, 32'h42);
    // Asynchronous reset in HALT: outputs drop at once, bad_addr clears.
    step("reset_in_halt", 0, 32'h104, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    boot_window("again");
    step("rerun_first", 1, 32'h00, 0, 0, 32'h0,   0, 0, 32'h04, 1, 0, 0, 0, 32'h0);

`ifdef FETCH_CTRL_PERF_EN
    step("perf_reset", 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    boot_window("perf");
    step("perf_r0", 1, 32'h00, 0, 0, 32'h0,  0, 0, 32'h04, 1, 0, 0, 0, 32'h0);
    step("perf_r1", 1, 32'h04, 1, 0, 32'h0,  0, 0, 32'h04, 1, 0, 0, 0, 32'h0);
    step("perf_r2", 1, 32'h04, 1, 0, 32'h0,  0, 0, 32'h04, 1, 0, 0, 0, 32'h0);
    step("perf_r3", 1, 32'h04, 0, 0, 32'h0,  0, 0, 32'h08, 1, 0, 0, 0, 32'h0);
    step("perf_r4", 1, 32'h08, 0, 1, 32'h60, 0, 0, 32'h60, 1, 1, 0, 0, 32'h0);
    step("perf_r5", 1, 32'h60, 0, 0, 32'h0,  0, 0, 32'h64, 1, 0, 0, 0, 32'h0);
    step("perf_r6", 1, 32'h64, 1, 0, 32'h0,  0, 0, 32'h64, 1, 0, 0, 0, 32'h0);
    step("perf_r7", 1, 32'h64, 0, 0, 32'h0,  0, 0, 32'h68, 1, 0, 0, 0, 32'h0);
    step("perf_r8", 1, 32'h68, 0, 0, 32'h0,  0, 0, 32'h6c, 1, 0, 0, 0, 32'h0);
    step("perf_r9", 1, 32'h6c, 0, 0, 32'h0,  0, 0, 32'h70, 1, 0, 0, 0, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    check("perf_fetch", {36'd0, perf_fetch}, 68'd7);
    check("perf_stall", {36'd0, perf_stall}, 68'd3);
    check("perf_flush", {36'd0, perf_flush}, 68'd1);
`endif

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected entries never compared, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
